// File: rtl/sub_serial_if.sv
// Handshake bundle for sub_serial: operand channel (in_*, I0, I1) and result
// channel (out_*, O, BORROW). The OVF line exists only when
// SUB_SERIAL_SIGNED_OVF_EN is defined.
// WIDTH must match the WIDTH of the sub_serial instance it is connected to.
interface sub_serial_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] O;
  logic             BORROW;
`ifdef SUB_SERIAL_SIGNED_OVF_EN
  logic             OVF;
`endif

`ifdef SUB_SERIAL_SIGNED_OVF_EN
  // Producer/consumer side: drives operands, takes results.
  modport master (
    output in_valid, I0, I1, out_ready,
    input  in_ready, out_valid, O, BORROW, OVF
  );

  // Subtractor side.
  modport slave (
    input  in_valid, I0, I1, out_ready,
    output in_ready, out_valid, O, BORROW, OVF
  );
`else
  // Producer/consumer side: drives operands, takes results.
  modport master (
    output in_valid, I0, I1, out_ready,
    input  in_ready, out_valid, O, BORROW
  );

  // Subtractor side.
  modport slave (
    input  in_valid, I0, I1, out_ready,
    output in_ready, out_valid, O, BORROW
  );
`endif
endinterface

// File: rtl/sub_serial.sv
// Bit-serial subtractor: O = I0 - I1 (mod 2^WIDTH), one bit per cycle, LSB
// first, with valid/ready handshakes on both sides.
// Optional feature macro: SUB_SERIAL_SIGNED_OVF_EN adds a signed-overflow
// flag (bus.OVF) loaded together with O/BORROW.
// Timing: accept edge, then WIDTH bit-step edges; out_valid is high in the
// cycle after the last step. With out_ready held high the issue interval is
// WIDTH+2 cycles.
module sub_serial #(
  parameter int unsigned WIDTH = 8
) (
  input logic         CLK,
  input logic         RESETN,
  sub_serial_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 2) begin : gen_bad_width
    $error("sub_serial: WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] o_q;
  logic             br_q;
  logic             borrow_q;
  logic [CntW-1:0]  cnt_q;
`ifdef SUB_SERIAL_SIGNED_OVF_EN
  // Sign bits are kept aside because a_q/b_q are shifted away during RUN.
  logic             a_msb_q;
  logic             b_msb_q;
  logic             ovf_q;
`endif

  logic             bit_d;
  logic             br_d;
  logic [WIDTH-1:0] r_d;
  logic             last_step;
  logic             accept;

  // One full-subtractor bit-step on the current LSBs plus handshake decode.
  always_comb begin
    bit_d     = a_q[0] ^ b_q[0] ^ br_q;
    br_d      = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    r_d       = {bit_d, r_q[WIDTH-1:1]};
    last_step = (cnt_q == CntW'(WIDTH - 1));
    accept    = bus.in_valid & in_ready_q;
  end

  // Control FSM and datapath; every output is registered.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      o_q         <= '0;
      br_q        <= 1'b0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
`ifdef SUB_SERIAL_SIGNED_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // in_ready_q is low only in the first cycle after reset release.
          in_ready_q <= 1'b1;
          if (accept) begin
            a_q        <= bus.I0;
            b_q        <= bus.I1;
            cnt_q      <= '0;
            br_q       <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
`ifdef SUB_SERIAL_SIGNED_OVF_EN
            a_msb_q    <= bus.I0[WIDTH-1];
            b_msb_q    <= bus.I1[WIDTH-1];
`endif
          end
        end
        StRun: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          r_q   <= r_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            o_q         <= r_d;
            borrow_q    <= br_d;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
`ifdef SUB_SERIAL_SIGNED_OVF_EN
            ovf_q       <= (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
`endif
          end
        end
        StDone: begin
          // in_ready stays low in the handshake cycle: no same-cycle re-accept.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.O         = o_q;
  assign bus.BORROW    = borrow_q;
`ifdef SUB_SERIAL_SIGNED_OVF_EN
  assign bus.OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Directed self-checking bench for sub_serial (WIDTH=8).
module tb_sub_serial;

  localparam int unsigned W = 8;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sub_serial_if #(.WIDTH(W)) bus ();

  sub_serial #(.WIDTH(W)) dut (
    .CLK    (clk),
    .RESETN (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present operands and hold in_valid until an accept edge has passed.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    bus.I0       = a;
    bus.I1       = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Cycles until out_valid is seen, or -1 if it never rises.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic release_result;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    resetn       = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.O !== 8'h00
        || bus.BORROW !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b O=%h BORROW=%b, want 0 0 00 0",
               bus.in_ready, bus.out_valid, bus.O, bus.BORROW);
    end
`ifdef SUB_SERIAL_SIGNED_OVF_EN
    checks++;
    if (bus.OVF !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", bus.OVF);
    end
`endif
    bus.in_valid = 1'b0;
    resetn       = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic [W-1:0] eo [3];
    logic         eb [3];
    int           lat;
    va = '{8'd10, 8'd3, 8'd0};
    vb = '{8'd3, 8'd10, 8'd0};
    eo = '{8'h07, 8'hF9, 8'h00};
    eb = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i]);
      wait_valid(lat);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL basic[%0d] latency: got %0d want 8", i, lat);
      end
      checks++;
      if (bus.O !== eo[i] || bus.BORROW !== eb[i]) begin
        errors++;
        $display("FAIL basic[%0d] result: O=%h BORROW=%b want O=%h BORROW=%b",
                 i, bus.O, bus.BORROW, eo[i], eb[i]);
      end
`ifdef SUB_SERIAL_SIGNED_OVF_EN
      checks++;
      if (bus.OVF !== 1'b0) begin
        errors++;
        $display("FAIL basic[%0d] ovf: got %b want 0", i, bus.OVF);
      end
`endif
      release_result();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.O !== eo[i] || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic[%0d] after_handshake: out_valid=%b O=%h in_ready=%b want 0 %h 1",
                 i, bus.out_valid, bus.O, bus.in_ready, eo[i]);
      end
    end
  endtask

  task automatic test_stall;
    int lat;
    issue(8'h55, 8'h0F);
    wait_valid(lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL stall latency: got %0d want 8", lat);
    end
    for (int k = 0; k < 5; k++) begin
      bus.in_valid  = (k % 2 == 0);
      bus.I0        = 8'hE0 + 8'(k);
      bus.I1        = 8'(k);
      bus.out_ready = 1'b0;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.O !== 8'h46 || bus.BORROW !== 1'b0
          || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: out_valid=%b O=%h BORROW=%b in_ready=%b want 1 46 0 0",
                 k, bus.out_valid, bus.O, bus.BORROW, bus.in_ready);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall handshake_in_ready: got %b want 0", bus.in_ready);
    end
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.O !== 8'h46) begin
      errors++;
      $display("FAIL stall release: out_valid=%b in_ready=%b O=%h want 0 1 46",
               bus.out_valid, bus.in_ready, bus.O);
    end
  endtask

  task automatic test_reset_mid_run;
    int   lat;
    logic seen;
    issue(8'h33, 8'h11);
    // Four bit-steps: cnt is now 4.
    for (int k = 0; k < 4; k++) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrun reset: out_valid=%b in_ready=%b want 0 0",
               bus.out_valid, bus.in_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      seen = seen | bus.out_valid;
    end
    checks++;
    if (seen !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun discard: out_valid_seen=%b in_ready=%b want 0 1",
               seen, bus.in_ready);
    end
    issue(8'hFF, 8'h01);
    wait_valid(lat);
    checks++;
    if (lat !== 8 || bus.O !== 8'hFE || bus.BORROW !== 1'b0) begin
      errors++;
      $display("FAIL midrun next_op: lat=%0d O=%h BORROW=%b want 8 FE 0",
               lat, bus.O, bus.BORROW);
    end
    release_result();
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [W-1:0] eo [4];
    logic         eb [4];
    logic         eovf [4];
    int           cyc;
    int           acc_n;
    int           res_n;
    int           last_acc;
    logic         acc_now;
    va   = '{8'hC8, 8'h12, 8'h7F, 8'hA5};
    vb   = '{8'h37, 8'h34, 8'h80, 8'hA5};
    eo   = '{8'h91, 8'hDE, 8'hFF, 8'h00};
    eb   = '{1'b0, 1'b1, 1'b1, 1'b0};
    eovf = '{1'b0, 1'b0, 1'b1, 1'b0};
    cyc      = 0;
    acc_n    = 0;
    res_n    = 0;
    last_acc = 0;
    bus.I0        = va[0];
    bus.I1        = vb[0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (res_n < 4 && cyc < 200) begin
      if (bus.out_valid) begin
        checks++;
        if (bus.O !== eo[res_n] || bus.BORROW !== eb[res_n]) begin
          errors++;
          $display("FAIL b2b[%0d] result: O=%h BORROW=%b want O=%h BORROW=%b",
                   res_n, bus.O, bus.BORROW, eo[res_n], eb[res_n]);
        end
`ifdef SUB_SERIAL_SIGNED_OVF_EN
        checks++;
        if (bus.OVF !== eovf[res_n]) begin
          errors++;
          $display("FAIL b2b[%0d] ovf: got %b want %b", res_n, bus.OVF, eovf[res_n]);
        end
`endif
        res_n++;
      end
      acc_now = bus.in_ready & bus.in_valid;
      tick();
      cyc++;
      if (acc_now) begin
        if (acc_n > 0) begin
          checks++;
          if (cyc - last_acc !== 10) begin
            errors++;
            $display("FAIL b2b[%0d] interval: got %0d want 10", acc_n, cyc - last_acc);
          end
        end
        last_acc = cyc;
        acc_n++;
        if (acc_n < 4) begin
          bus.I0 = va[acc_n];
          bus.I1 = vb[acc_n];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (res_n !== 4) begin
      errors++;
      $display("FAIL b2b count: got %0d results want 4", res_n);
    end
  endtask

`ifdef SUB_SERIAL_SIGNED_OVF_EN
  task automatic test_ovf;
    logic [W-1:0] va [2];
    logic [W-1:0] vb [2];
    logic [W-1:0] eo [2];
    logic         eovf [2];
    int           lat;
    va   = '{8'h80, 8'h05};
    vb   = '{8'h01, 8'h03};
    eo   = '{8'h7F, 8'h02};
    eovf = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      issue(va[i], vb[i]);
      wait_valid(lat);
      checks++;
      if (lat !== 8 || bus.O !== eo[i] || bus.OVF !== eovf[i] || bus.BORROW !== 1'b0) begin
        errors++;
        $display("FAIL ovf[%0d]: lat=%0d O=%h OVF=%b BORROW=%b want 8 %h %b 0",
                 i, lat, bus.O, bus.OVF, bus.BORROW, eo[i], eovf[i]);
      end
      release_result();
    end
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.I0        = '0;
    bus.I1        = '0;
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SUB_SERIAL_SIGNED_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
